// File: rtl/des_align_160.sv
// Serial-to-parallel receiver: shifts 1-bit stream, hunts/verifies a sync word, forwards data words once locked.
// Data words appear 1 clock after the enabled cycle carrying their LSB; enable=0 freezes all state.
module des_align_160 #(
   parameter logic [7:0] SYNC_WORD  = 8'hBC,
   parameter int          FRAME_LEN  = 4,
   parameter int          LOCK_COUNT = 3,
   parameter int          MISS_LIMIT = 2
) (
   input  logic       clock_160,
   input  logic       reset,
   input  logic       enable,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       locked,
   output logic       sync_err
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] SYNC_SLOT = 4'(FRAME_LEN);
   localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
   localparam logic [3:0] MISS_N    = 4'(MISS_LIMIT);

   state_t     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] word_cnt_q, word_cnt_d;
   logic [3:0] match_cnt_q, match_cnt_d;
   logic [3:0] miss_cnt_q, miss_cnt_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;
   logic       locked_q, locked_d;
   logic       sync_err_q, sync_err_d;

   logic [7:0] cur;
   logic       sync_hit;
   logic       word_done;
   logic       sync_slot;

   assign cur       = {sr_q[6:0], data_in};
   assign sync_hit  = (cur == SYNC_WORD);
   assign word_done = (bit_cnt_q == 3'd7);
   assign sync_slot = (word_cnt_q == SYNC_SLOT);

   always_ff @(posedge clock_160) begin
      if (reset) begin
         state_q      <= HUNT;
         sr_q         <= 8'h00;
         bit_cnt_q    <= 3'd0;
         word_cnt_q   <= 4'd0;
         match_cnt_q  <= 4'd0;
         miss_cnt_q   <= 4'd0;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         locked_q     <= locked_d;
         sync_err_q   <= sync_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            HUNT: begin
               if (sync_hit) state_d = VERIFY;
            end
            VERIFY: begin
               if (word_done && sync_slot) begin
                  if (!sync_hit)
                     state_d = HUNT;
                  else if (match_cnt_q + 4'd1 == LOCK_N)
                     state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (word_done && sync_slot && !sync_hit && (miss_cnt_q + 4'd1 == MISS_N))
                  state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      match_cnt_d  = match_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      sync_err_d   = 1'b0;
      if (enable) begin
         sr_d = cur;
         if (state_q == HUNT) begin
            if (sync_hit) begin
               bit_cnt_d   = 3'd0;
               word_cnt_d  = 4'd0;
               match_cnt_d = 4'd1;
               miss_cnt_d  = 4'd0;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (word_done) begin
               if (sync_slot) begin
                  word_cnt_d = 4'd0;
                  if (state_q == VERIFY) begin
                     if (sync_hit) match_cnt_d = match_cnt_q + 4'd1;
                  end else if (sync_hit) begin
                     miss_cnt_d = 4'd0;
                  end else begin
                     sync_err_d = 1'b1;
                     miss_cnt_d = miss_cnt_q + 4'd1;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + 4'd1;
                  if (state_q == LOCKED) begin
                     data_out_d   = cur;
                     data_valid_d = 1'b1;
                  end
               end
            end
         end
         // Any fall back to HUNT restarts alignment from scratch.
         if (state_d == HUNT && state_q != HUNT) begin
            bit_cnt_d   = 3'd0;
            word_cnt_d  = 4'd0;
            match_cnt_d = 4'd0;
            miss_cnt_d  = 4'd0;
         end
      end
   end

   assign locked_d   = (state_d == LOCKED);
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign locked     = locked_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_des_align_160.sv
// Bench for des_align_160: scenario table plus hand-written lock-loss, failed-verify and reset sequences.
module tb_des_align_160;

   logic       clock_160 = 1'b0;
   logic       reset     = 1'b1;
   logic       enable    = 1'b0;
   logic       data_in   = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       locked;
   logic       sync_err;

   des_align_160 dut (
      .clock_160 (clock_160),
      .reset     (reset),
      .enable    (enable),
      .data_in   (data_in),
      .data_out  (data_out),
      .data_valid(data_valid),
      .locked    (locked),
      .sync_err  (sync_err)
   );

   always #5 clock_160 = ~clock_160;

   int         checks  = 0;
   int         errors  = 0;
   int         n_valid = 0;
   int         n_err   = 0;
   logic [7:0] exp_q[$];
   logic       gap     = 1'b0;
   logic       lk_pre, lk_post, se_post;
   logic [7:0] dw[4];

   typedef struct {
      string name;
      logic  gap;
      int    nfr;
      int    exp_valid;
      logic  exp_locked;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock with the given inputs; outputs sampled 1 time unit after the edge.
   task automatic cyc(input logic en, input logic b);
      logic [7:0] w;
      enable  = en;
      data_in = b;
      @(posedge clock_160);
      #1;
      if (data_valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got %0h expected no data_valid", data_out);
         end else begin
            w = exp_q.pop_front();
            chk("data_word", data_out, w);
         end
      end
      if (sync_err === 1'b1) n_err++;
   endtask

   task automatic idle_cycle();
      logic [7:0] d0;
      logic       l0;
      d0 = data_out;
      l0 = locked;
      cyc(1'b0, 1'($urandom));
      chk("hold_valid", data_valid, 0);
      chk("hold_err", sync_err, 0);
      chk("hold_dout", data_out, d0);
      chk("hold_lock", locked, l0);
   endtask

   task automatic send_bit(input logic b);
      cyc(1'b1, b);
      if (gap) idle_cycle();
   endtask

   task automatic send_byte(input logic [7:0] w, input logic fwd);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) begin
            lk_pre = locked;
            if (fwd) exp_q.push_back(w);
         end
         cyc(1'b1, w[i]);
         if (i == 0) begin
            chk("valid_latency", data_valid, fwd);
            lk_post = locked;
            se_post = sync_err;
         end
         if (gap) idle_cycle();
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'($urandom));
         chk("rst_dout", data_out, 0);
         chk("rst_valid", data_valid, 0);
         chk("rst_locked", locked, 0);
         chk("rst_err", sync_err, 0);
      end
      reset   = 1'b0;
      n_valid = 0;
      n_err   = 0;
   endtask

   task automatic send_prefix();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
   endtask

   // Frames [BC, 11, 22, 33, 44] from HUNT: lock lands on the 3rd BC, data forwarded from then on.
   task automatic run_frames(input int n);
      for (int f = 1; f <= n; f++) begin
         send_byte(8'hBC, 1'b0);
         if (f < 3) chk("not_locked_yet", lk_post, 0);
         else if (f == 3) begin
            chk("lock_before_3rd_bc", lk_pre, 0);
            chk("lock_after_3rd_bc", lk_post, 1);
         end else chk("stay_locked", lk_post, 1);
         for (int k = 0; k < 4; k++) send_byte(dw[k], f >= 3);
      end
   endtask

   initial begin
      dw[0] = 8'h11; dw[1] = 8'h22; dw[2] = 8'h33; dw[3] = 8'h44;
      tbl[0] = '{name: "cont5",  gap: 1'b0, nfr: 5, exp_valid: 12, exp_locked: 1'b1};
      tbl[1] = '{name: "gap5",   gap: 1'b1, nfr: 5, exp_valid: 12, exp_locked: 1'b1};
      tbl[2] = '{name: "short2", gap: 1'b0, nfr: 2, exp_valid: 0,  exp_locked: 1'b0};
      tbl[3] = '{name: "min3",   gap: 1'b0, nfr: 3, exp_valid: 4,  exp_locked: 1'b1};

      do_reset(3);

      for (int t = 0; t < 4; t++) begin
         do_reset(1);
         gap = tbl[t].gap;
         send_prefix();
         run_frames(tbl[t].nfr);
         chk({tbl[t].name, "_valid_cnt"}, n_valid, tbl[t].exp_valid);
         chk({tbl[t].name, "_locked"}, locked, tbl[t].exp_locked);
         chk({tbl[t].name, "_q_empty"}, exp_q.size(), 0);
         gap = 1'b0;
      end

      // Failed verify: 00 in the first sync slot, then a fresh 3-match relock.
      do_reset(1);
      send_prefix();
      send_byte(8'hBC, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(dw[k], 1'b0);
      send_byte(8'h00, 1'b0);
      chk("fv_locked", lk_post, 0);
      chk("fv_no_valid", n_valid, 0);
      run_frames(3);
      chk("fv_relock_valid", n_valid, 4);
      chk("fv_q_empty", exp_q.size(), 0);

      // Loss of lock: single miss tolerated, two consecutive misses drop lock.
      do_reset(1);
      send_prefix();
      run_frames(5);
      send_byte(8'h00, 1'b0);
      chk("miss1_err", se_post, 1);
      chk("miss1_locked", lk_post, 1);
      for (int k = 0; k < 4; k++) send_byte(dw[k], 1'b1);
      send_byte(8'hBC, 1'b0);
      chk("recover_err", se_post, 0);
      chk("recover_locked", lk_post, 1);
      for (int k = 0; k < 4; k++) send_byte(dw[k], 1'b1);
      send_byte(8'h00, 1'b0);
      chk("miss2a_err", se_post, 1);
      chk("miss2a_locked", lk_post, 1);
      for (int k = 0; k < 4; k++) send_byte(dw[k], 1'b1);
      send_byte(8'h00, 1'b0);
      chk("miss2b_err", se_post, 1);
      chk("miss2b_locked", lk_post, 0);
      send_byte(8'h11, 1'b0);
      chk("miss_err_pulses", n_err, 3);
      chk("miss_q_empty", exp_q.size(), 0);

      // Reset mid-word while locked, then relock requires three new matches.
      do_reset(1);
      send_prefix();
      run_frames(3);
      send_byte(8'hBC, 1'b0);
      send_byte(8'h11, 1'b1);
      chk("pre_rst_dout", data_out, 8'h11);
      for (int i = 7; i >= 4; i--) send_bit(dw[1][i]);
      reset = 1'b1;
      cyc(1'b1, 1'($urandom));
      reset = 1'b0;
      chk("midrst_locked", locked, 0);
      chk("midrst_valid", data_valid, 0);
      chk("midrst_dout", data_out, 0);
      n_valid = 0;
      for (int i = 3; i >= 0; i--) send_bit(dw[1][i]);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      run_frames(3);
      chk("midrst_relock_valid", n_valid, 4);
      chk("midrst_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_align_160.md
DES_ALIGN_160 -- requirements
Module: des_align_160

Purpose: serial-to-parallel receiver that sits downstream of the 160 MHz serializer. It recovers 8-bit words from the 1-bit stream, aligns to a sync word and forwards the data words.

Interface
REQ-001 Parameter SYNC_WORD, default 8'hBC, frame alignment word.
REQ-002 Parameter FRAME_LEN, default 4, data words following each sync word; legal range 1..15.
REQ-003 Parameter LOCK_COUNT, default 3, consecutive sync matches needed to lock; legal range 2..15.
REQ-004 Parameter MISS_LIMIT, default 2, consecutive sync misses that drop lock; legal range 1..15.
REQ-005 clock_160  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  bit qualifier; data_in is sampled only on cycles with enable=1.
REQ-008 data_in  in  1  serial bit stream, MSB of each word first.
REQ-009 data_out  out  8  recovered data word, registered.
REQ-010 data_valid  out  1  one-cycle pulse; data_out holds a new data word.
REQ-011 locked  out  1  high while the state is LOCKED.
REQ-012 sync_err  out  1  one-cycle pulse on a missed sync slot while LOCKED.

Function
REQ-013 Shift register: sr <= {sr[6:0], data_in} on each enabled cycle; cur = {sr[6:0], data_in} is the candidate word.
REQ-014 On enable=0 all state holds: sr, counters, FSM and data_out; data_valid and sync_err are 0.
REQ-015 FSM states: HUNT, VERIFY, LOCKED.
REQ-016 HUNT, on each enabled bit:
- if cur == SYNC_WORD: go to VERIFY with bit_cnt=0, word_cnt=0 (next word is data slot 0), match_cnt=1.
- otherwise remain in HUNT.
REQ-017 In VERIFY and LOCKED, bit_cnt counts enabled bits 0..7; the 8th bit (bit_cnt=7) completes a word; bit_cnt wraps to 0.
REQ-018 Word slots: word_cnt 0..FRAME_LEN-1 are data slots; word_cnt == FRAME_LEN is the sync slot; word_cnt wraps to 0 after the sync slot.
REQ-019 VERIFY, data slots: words are discarded; no data_valid.
REQ-020 VERIFY, sync slot:
- cur == SYNC_WORD: match_cnt++; if match_cnt reaches LOCK_COUNT, go to LOCKED.
- mismatch: return to HUNT and clear all counters.
REQ-021 LOCKED, data slot: on word completion, data_out <= cur and data_valid=1 on the following cycle (latency 1 clock after the enabled cycle carrying the word's LSB).
REQ-022 LOCKED, data slot containing SYNC_WORD: forwarded as ordinary data.
REQ-023 LOCKED, sync slot:
- match: miss_cnt cleared; word not forwarded.
- mismatch: sync_err pulses for 1 cycle and miss_cnt++.
- if miss_cnt reaches MISS_LIMIT: go to HUNT; locked=0 on the next cycle; counters cleared.
REQ-024 Sync slots are never forwarded; data_valid is never asserted outside LOCKED.
REQ-025 locked is registered and reflects the state of the previous edge; in LOCKED, locked=1 from the cycle after the transition.
REQ-026 Counter widths hold their maximum parameter value without overflow; wrap is only by explicit rules above.

Reset
REQ-027 reset=1 on a clock edge: state=HUNT, sr=0, all counters=0, data_out=8'h00, data_valid=0, locked=0, sync_err=0.
REQ-028 reset has priority over enable and over any in-progress transition, including mid-word and mid-frame.
REQ-029 After reset, relock requires a full HUNT and LOCK_COUNT matches.

Verification
REQ-030 Reset check: reset=1 for 3 cycles with random data_in and enable=1 -> all outputs 0 throughout; locked=0.
REQ-031 Lock and data, enable=1 continuously, defaults, stimulus: bits 101, then 5 frames of [BC,11,22,33,44] MSB-first:
- locked=1 starting 1 cycle after the 3rd BC completes;
- data_valid pulses with 11,22,33,44 for frames 3..5, each pulse 1 cycle after the word's LSB;
- no pulse for BC.
REQ-032 Gapped enable: same stream with enable toggling 1/0 every cycle -> identical data_out sequence; every data_valid follows an enabled cycle; no state change on enable=0 cycles.
REQ-033 Failed verify: BC, then 11,22,33,44, then 00 in the sync slot -> back to HUNT; locked stays 0; no data_valid.
REQ-034 Loss of lock, when LOCKED:
- one sync slot 00, then BC -> sync_err pulses once; locked stays 1.
- two consecutive sync slots 00 -> sync_err pulses twice; locked=0 after the second.
REQ-035 Reset mid-frame while LOCKED (after 4 bits of word 22) -> next cycle locked=0, data_valid=0, data_out=00; resumed stream relocks only after 3 further BC matches.
